// File: rtl/adc_vol_filter.sv
// ---------------------------------------------------------------------------
// adc_vol_filter
//
// Conditions the modular ADC response stream for the voltage consumers
// (LED bar, 7-segment digits, acceleration/pick logic). Samples from one
// selected channel feed a 2^AVG_LOG2-deep moving average. The average is
// scaled to millivolts (0..5000) and also held behind a hysteresis band, so
// the display and the pick motion do not jitter.
//
// Pipeline (one sample per clock, no stall):
//   stage 1 (accept edge) : window write, running sum, write pointer, fill
//   stage 2               : prod = (sum >> AVG_LOG2) * 10003
//   stage 3               : vol_mv = prod >> 13, hysteresis update
//
// Ports:
//   sys_clk           system clock
//   Reset             asynchronous, active-high reset
//   sel_channel       channel accepted by the filter
//   response_valid    ADC response strobe (one sample per high cycle)
//   response_channel  channel tag of the current response
//   response_data     raw 12-bit ADC code
//   vol_mv            filtered voltage in mV
//   vol_valid         one-cycle pulse when vol_mv updates
//   vol_stable        hysteresis-held voltage in mV
//   stable_upd        one-cycle pulse when vol_stable changes
//   primed            window full, outputs meaningful
//
// Optional feature, enabled by defining ADC_FILT_MINMAX_EN:
//   minmax_clr        synchronous clear of the extremes (beats an update)
//   vol_min, vol_max  running extremes of vol_mv
// ---------------------------------------------------------------------------
module adc_vol_filter #(
    parameter int AVG_LOG2 = 3,
    parameter int HYST_MV  = 50
) (
    input  logic        sys_clk,
    input  logic        Reset,
    input  logic [4:0]  sel_channel,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    output logic [12:0] vol_mv,
    output logic        vol_valid,
    output logic [12:0] vol_stable,
    output logic        stable_upd,
    output logic        primed
`ifdef ADC_FILT_MINMAX_EN
    ,
    input  logic        minmax_clr,
    output logic [12:0] vol_min,
    output logic [12:0] vol_max
`endif
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 12 + AVG_LOG2;

    // Stage 1 state
    logic [11:0]         win_q [DEPTH];
    logic [AVG_LOG2-1:0] wptr_q;
    logic [AVG_LOG2:0]   fill_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic                s1_vld_q;
    logic                primed_q;

    // Stage 2 state
    logic [11:0]         avg_d;
    logic [25:0]         prod_d;
    logic [25:0]         prod_q;
    logic                s2_vld_q;

    // Stage 3 / output state
    logic [12:0]         mv_d;
    logic [13:0]         diff_d;
    logic [13:0]         adiff_d;
    logic                hyst_hit_d;
    logic [12:0]         vol_mv_q;
    logic                vol_valid_q;
    logic [12:0]         vol_stable_q;
    logic                stable_upd_q;
    logic                have_stable_q;

    logic                accept;
    logic                fill_last;

    assign accept    = response_valid && (response_channel == sel_channel);
    // True when the current accept completes (or is beyond) the first window.
    assign fill_last = (fill_q >= (AVG_LOG2 + 1)'(DEPTH - 1));

    // The oldest sample leaves the sum as the new one enters. The window
    // resets to zeros, so the sum never exceeds DEPTH * 4095.
    assign sum_d  = sum_q + SUM_W'(response_data) - SUM_W'(win_q[wptr_q]);
    assign avg_d  = 12'(sum_q >> AVG_LOG2);
    assign prod_d = 26'(avg_d) * 26'd10003;
    assign mv_d   = 13'(prod_q >> 13);

    // 14-bit signed distance between the new value and the held value.
    assign diff_d     = {1'b0, mv_d} - {1'b0, vol_stable_q};
    assign adiff_d    = diff_d[13] ? (14'd0 - diff_d) : diff_d;
    assign hyst_hit_d = (adiff_d >= 14'(HYST_MV));

    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
            wptr_q        <= '0;
            fill_q        <= '0;
            sum_q         <= '0;
            s1_vld_q      <= 1'b0;
            primed_q      <= 1'b0;
            prod_q        <= '0;
            s2_vld_q      <= 1'b0;
            vol_mv_q      <= '0;
            vol_valid_q   <= 1'b0;
            vol_stable_q  <= '0;
            stable_upd_q  <= 1'b0;
            have_stable_q <= 1'b0;
        end else begin
            // Stage 1
            s1_vld_q <= accept && fill_last;
            if (accept) begin
                win_q[wptr_q] <= response_data;
                wptr_q        <= wptr_q + 1'b1;
                sum_q         <= sum_d;
                if (!fill_q[AVG_LOG2]) fill_q <= fill_q + 1'b1;
                if (fill_last) primed_q <= 1'b1;
            end

            // Stage 2
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) prod_q <= prod_d;

            // Stage 3: the first result after reset always loads the held value
            vol_valid_q  <= s2_vld_q;
            stable_upd_q <= 1'b0;
            if (s2_vld_q) begin
                vol_mv_q <= mv_d;
                if (!have_stable_q || hyst_hit_d) begin
                    vol_stable_q  <= mv_d;
                    stable_upd_q  <= 1'b1;
                    have_stable_q <= 1'b1;
                end
            end
        end
    end

    assign vol_mv     = vol_mv_q;
    assign vol_valid  = vol_valid_q;
    assign vol_stable = vol_stable_q;
    assign stable_upd = stable_upd_q;
    assign primed     = primed_q;

`ifdef ADC_FILT_MINMAX_EN
    logic [12:0] vol_min_q;
    logic [12:0] vol_max_q;

    // Reset/clear values make the first update load both extremes.
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            vol_min_q <= 13'h1FFF;
            vol_max_q <= '0;
        end else if (minmax_clr) begin
            vol_min_q <= 13'h1FFF;
            vol_max_q <= '0;
        end else if (s2_vld_q) begin
            if (mv_d < vol_min_q) vol_min_q <= mv_d;
            if (mv_d > vol_max_q) vol_max_q <= mv_d;
        end
    end

    assign vol_min = vol_min_q;
    assign vol_max = vol_max_q;
`endif

endmodule

// File: tb/tb_adc_vol_filter.sv
// Testbench for adc_vol_filter (AVG_LOG2=3, HYST_MV=50).
module tb_adc_vol_filter;

    localparam int N    = 8;
    localparam int HYST = 50;

    logic        sys_clk = 1'b0;
    logic        Reset   = 1'b1;
    logic [4:0]  sel_channel = 5'd1;
    logic        response_valid = 1'b0;
    logic [4:0]  response_channel = 5'd0;
    logic [11:0] response_data = 12'd0;
    logic [12:0] vol_mv;
    logic        vol_valid;
    logic [12:0] vol_stable;
    logic        stable_upd;
    logic        primed;
`ifdef ADC_FILT_MINMAX_EN
    logic        minmax_clr = 1'b0;
    logic [12:0] vol_min;
    logic [12:0] vol_max;
`endif

    adc_vol_filter #(.AVG_LOG2(3), .HYST_MV(HYST)) dut (
        .sys_clk          (sys_clk),
        .Reset            (Reset),
        .sel_channel      (sel_channel),
        .response_valid   (response_valid),
        .response_channel (response_channel),
        .response_data    (response_data),
        .vol_mv           (vol_mv),
        .vol_valid        (vol_valid),
        .vol_stable       (vol_stable),
        .stable_upd       (stable_upd),
        .primed           (primed)
`ifdef ADC_FILT_MINMAX_EN
        ,
        .minmax_clr       (minmax_clr),
        .vol_min          (vol_min),
        .vol_max          (vol_max)
`endif
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          hist[$];        // last N accepted codes
    int          n_acc = 0;      // accepted samples since reset (saturating)
    logic [12:0] exp_q[$];       // expected vol_mv values in order
    int          due_q[$];       // cycle at which each value must appear
    bit          m_have_stable = 0;
    int          m_stable = 0;
    int          m_min = 13'h1FFF;
    int          m_max = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int window_mv();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return ((s / N) * 10003) / 8192;
    endfunction

    task automatic model_clear();
        hist.delete();
        exp_q.delete();
        due_q.delete();
        n_acc = 0;
        m_have_stable = 0;
        m_stable = 0;
        m_min = 13'h1FFF;
        m_max = 0;
    endtask

    task automatic model_accept(input int code);
        hist.push_back(code);
        if (hist.size() > N) void'(hist.pop_front());
        if (n_acc < N) n_acc++;
        if (n_acc == N) begin
            exp_q.push_back(13'(window_mv()));
            due_q.push_back(cyc + 2);
        end
    endtask

    task automatic check_outputs();
        int mv;
        bit upd;
        chk("primed", primed, (n_acc == N));
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            mv = int'(exp_q.pop_front());
            upd = !m_have_stable || (mv - m_stable >= HYST) || (m_stable - mv >= HYST);
            if (upd) begin
                m_stable = mv;
                m_have_stable = 1;
            end
            if (mv < m_min) m_min = mv;
            if (mv > m_max) m_max = mv;
            chk("vol_valid", vol_valid, 1);
            chk("vol_mv", vol_mv, mv);
            chk("stable_upd", stable_upd, upd);
        end else begin
            chk("vol_valid_idle", vol_valid, 0);
            chk("stable_upd_idle", stable_upd, 0);
        end
        chk("vol_stable", vol_stable, m_stable);
`ifdef ADC_FILT_MINMAX_EN
        chk("vol_min", vol_min, m_min);
        chk("vol_max", vol_max, m_max);
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [4:0] ch, input logic [11:0] d);
        @(negedge sys_clk);
        response_valid   = v;
        response_channel = ch;
        response_data    = d;
        @(posedge sys_clk);
        cyc++;
        if (v && ch == sel_channel) model_accept(int'(d));
        #1 check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 12'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mv"}, vol_mv, 0);
        chk({tag, "_valid"}, vol_valid, 0);
        chk({tag, "_stable"}, vol_stable, 0);
        chk({tag, "_upd"}, stable_upd, 0);
        chk({tag, "_primed"}, primed, 0);
    endtask

    // Assert Reset between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        response_valid = 1'b0;
        @(posedge sys_clk);
        #2 Reset = 1'b1;
        #1 check_zero("async_rst");
        model_clear();
        @(posedge sys_clk);
        @(negedge sys_clk);
        Reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #3 check_zero("por");
        @(negedge sys_clk);
        @(negedge sys_clk);
        Reset = 1'b0;

        // Fill and latency at mid-scale
        for (int i = 0; i < N; i++) step(1'b1, 5'd1, 12'd2048);
        idle(3);
        chk("fill_mv", vol_mv, 2500);
        chk("fill_stable", vol_stable, 2500);

        // Full-scale step from zero
        async_reset();
        for (int i = 0; i < N; i++) step(1'b1, 5'd1, 12'd0);
        step(1'b1, 5'd1, 12'd4095);
        idle(2);
        chk("step1_mv", vol_mv, 623);
        chk("step1_stable", vol_stable, 623);
        for (int i = 0; i < N - 1; i++) step(1'b1, 5'd1, 12'd4095);
        idle(3);
        chk("fullscale_mv", vol_mv, 5000);
        chk("fullscale_stable", vol_stable, 5000);

        // Hysteresis band
        async_reset();
        for (int i = 0; i < N; i++) step(1'b1, 5'd1, 12'd2048);
        for (int i = 0; i < 16; i++) step(1'b1, 5'd1, (i % 2) ? 12'd2090 : 12'd2048);
        idle(3);
        chk("hyst_stable", vol_stable, 2500);

        // Channel filter: channel 2 full-scale must never leak in
        async_reset();
        for (int i = 0; i < 24; i++) begin
            if (i % 2) step(1'b1, 5'd2, 12'd4095);
            else       step(1'b1, 5'd1, 12'd0);
        end
        idle(3);
        chk("chan_mv", vol_mv, 0);

        // Back-to-back ramp through the pointer wrap
        async_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 5'd1, 12'(i));
        idle(3);

        // Reset with samples in flight, then refill
        for (int i = 0; i < 5; i++) step(1'b1, 5'd1, 12'd3000);
        async_reset();
        for (int i = 0; i < N; i++) step(1'b1, 5'd1, 12'd1000);
        idle(3);

        // Random traffic, mixing large jumps with small wiggles
        begin
            int base = 2000;
            for (int i = 0; i < 400; i++) begin
                logic [11:0] d;
                if ($urandom_range(0, 3) == 0) base = $urandom_range(0, 4095);
                d = 12'(base + $urandom_range(0, 60) > 4095 ? 4095 : base + $urandom_range(0, 60));
                step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 2)), d);
                if (i == 200) async_reset();
            end
        end
        idle(4);

        chk("drain_empty", due_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_vol_filter.md
Name: adc_vol_filter

Overview:
- Downstream conditioning stage for the modular ADC response stream. It sits between the adc_qsys response interface and the voltage consumers: LED bar, 7-segment digit logic, and the acceleration/pick logic.
- Keeps a sliding-window moving average of raw 12-bit samples from one selected channel and scales it to millivolts (0..5000).
- Outputs a per-sample filtered value and a hysteresis-held stable value. The stable value keeps the display and pick motion from jittering.

Parameters:
- AVG_LOG2, 3, log2 of window depth (window = 2^AVG_LOG2 samples); legal range 1..6.
- HYST_MV, 50, minimum |vol_mv - vol_stable| in mV that updates vol_stable.

Ports:
- sys_clk  input  1  system clock (ADC clock-bridge output).
- Reset  input  1  asynchronous, active-high reset.
- sel_channel  input  5  ADC channel accepted by the filter.
- response_valid  input  1  ADC response strobe; one sample per high cycle.
- response_channel  input  5  channel tag of the current response.
- response_data  input  12  raw ADC code.
- vol_mv  output  13  filtered voltage in mV.
- vol_valid  output  1  one-cycle pulse when vol_mv updates.
- vol_stable  output  13  hysteresis-held voltage in mV.
- stable_upd  output  1  one-cycle pulse when vol_stable changes.
- primed  output  1  window full; outputs meaningful.

Behaviour:
- Reset (async, active-high): clears buffer, running sum, write pointer, fill count, and pipeline registers. vol_mv=0, vol_valid=0, vol_stable=0, stable_upd=0, primed=0.
- Accept rule: a sample is accepted on a sys_clk edge where response_valid=1 and response_channel==sel_channel. All other responses are ignored with no state change.
- Full rate is supported: back-to-back accepts on every cycle, no stall, no drops.
- Buffer: 2^AVG_LOG2 x 12-bit circular buffer with write pointer wptr; wptr wraps from 2^AVG_LOG2-1 to 0.
- Stage 1 (acceptance edge):
  - sum <= sum + response_data - buf[wptr]; buf[wptr] <= response_data; wptr <= wptr+1.
  - sum width is 12+AVG_LOG2 bits and never overflows, because the buffer is reset to zeros.
- Fill: fill count saturates at 2^AVG_LOG2.
  - primed rises on the edge that writes the 2^AVG_LOG2-th accepted sample after reset.
  - Samples accepted before that point produce no vol_valid.
- Stage 2 (next edge): avg = sum >> AVG_LOG2; prod <= avg * 10003 (26 bits).
- Stage 3 (next edge):
  - vol_mv <= prod >> 13; vol_valid <= 1 for one cycle.
  - Total latency is 2 clocks from the acceptance edge to vol_valid high.
  - The result is exact for the stated formula; code 4095 -> 5000, code 2048 -> 2500.
- Stable update: evaluated in the same cycle vol_mv is loaded.
  - First vol_valid after reset: vol_stable loads unconditionally; stable_upd=1.
  - Otherwise, if |new vol_mv - vol_stable| >= HYST_MV: vol_stable <= new vol_mv; stable_upd=1. Else both are unchanged and stable_upd=0.
  - The comparison uses a 14-bit signed difference.
- sel_channel change mid-stream:
  - No automatic flush; old-channel samples age out of the window.
  - The owner must assert Reset for a clean start.
- Reset mid-pipeline: in-flight samples are discarded; no vol_valid appears after Reset deasserts until the window refills.

Optional Feature:
- Macro ADC_FILT_MINMAX_EN.
- Defined:
  - Adds outputs vol_min[12:0] and vol_max[12:0], plus input minmax_clr.
  - On each vol_valid, vol_min/vol_max track the running extremes of vol_mv.
  - The first vol_valid after Reset or minmax_clr loads both.
  - Reset values: vol_min=13'h1FFF, vol_max=0.
  - minmax_clr is synchronous and takes priority over the update in the same cycle.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Fill/latency: AVG_LOG2=3; 8 accepted samples of 2048, one per cycle.
  - No vol_valid during samples 1-7.
  - primed=1 after the 8th edge; vol_valid 2 clocks later with vol_mv=2500, vol_stable=2500, stable_upd=1.
- Full scale and step: prime with code 0 (vol_mv=0, vol_stable=0 after the unconditional first load), then one sample of 4095.
  - vol_mv=623; stable_upd=1 with vol_stable=623.
  - After 7 more samples of 4095: vol_mv=5000, vol_stable=5000.
- Hysteresis: primed at 2048 (vol_stable=2500), then alternate codes 2048/2090.
  - vol_mv moves by less than 50 mV, so vol_stable stays 2500 and stable_upd stays 0.
- Channel filter: sel_channel=1; valid responses on channel 2 with code 4095 interleaved with channel-1 code 0.
  - vol_mv stays 0; vol_valid pulses only for channel-1 samples.
- Wrap/back-to-back: response_valid held high for 20 cycles on a 0..19 ramp.
  - Verify wptr wrap.
  - vol_mv equals ((sum of last 8 codes)>>3)*10003>>13 each cycle; no dropped pulses.
- Async reset mid-stream: assert Reset between edges during the stream.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, 8 new samples are required before vol_valid.
